mem_stage: RTL

Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back. Holds one instruction in a pipeline register under a valid/allowin handshake. Receives the synchronous data-RAM read word one cycle after the execute stage issued the address, and keeps that word in a hold register across write-back stalls. Produces the extended and merged load result (LB/LBU/LH/LHU/LW/LWL/LWR) and forwards exception, CP0 and write-back control to write-back.

---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/mem_stage_load_align.sv | 45 ++++
 rtl/mem_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: load-type encodings,
// LWL/LWR one-hot layout and the reset image of the pipeline payload.
package mem_stage_pkg;

   localparam int LUB_LW  = 0;
   localparam int LUB_LB  = 1;
   localparam int LUB_LBU = 2;
   localparam int LUB_LH  = 3;
   localparam int LUB_LHU = 4;

   // onehot[OH_LWL+k] is LWL at byte offset k, onehot[OH_LWR+k] is LWR
   localparam int OH_LWL = 0;
   localparam int OH_LWR = 4;

   typedef struct packed {
      logic [31:0] alures;
      logic [4:0]  sel_wbdata;
      logic [4:0]  lubhw_con;
      logic [7:0]  onehot;
      logic [31:0] pc;
      logic [31:0] nnpc;
      logic [4:0]  wnum;
      logic [2:0]  write_type;
      logic        exception;
      logic        bd;
      logic        eret;
      logic [4:0]  exc_code;
      logic [7:0]  cp0_addr;
      logic [1:0]  mftc0_op;
      logic [31:0] mtc0_data;
      logic [31:0] error_vaddr;
   } mem_pl_t;

   localparam mem_pl_t INI_PL = '0;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load result formatter: byte/half extension and LWL/LWR merge with rt.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_rt,
   input  logic [1:0]  i_addr,
   input  logic [4:0]  i_lubhw_con,
   input  logic [7:0]  i_onehot,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
   assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_load_data = '0;
      if (|i_onehot) begin
         unique case (1'b1)
            i_onehot[OH_LWL+0]: o_load_data = {i_rdata[7:0], i_rt[23:0]};
            i_onehot[OH_LWL+1]: o_load_data = {i_rdata[15:0], i_rt[15:0]};
            i_onehot[OH_LWL+2]: o_load_data = {i_rdata[23:0], i_rt[7:0]};
            i_onehot[OH_LWL+3]: o_load_data = i_rdata;
            i_onehot[OH_LWR+0]: o_load_data = i_rdata;
            i_onehot[OH_LWR+1]: o_load_data = {i_rt[31:24], i_rdata[31:8]};
            i_onehot[OH_LWR+2]: o_load_data = {i_rt[31:16], i_rdata[31:16]};
            i_onehot[OH_LWR+3]: o_load_data = {i_rt[31:8], i_rdata[31:24]};
            default:            o_load_data = '0;
         endcase
      end else begin
         unique case (1'b1)
            i_lubhw_con[LUB_LW]:  o_load_data = i_rdata;
            i_lubhw_con[LUB_LB]:  o_load_data = {{24{w_byte[7]}}, w_byte};
            i_lubhw_con[LUB_LBU]: o_load_data = {24'd0, w_byte};
            i_lubhw_con[LUB_LH]:  o_load_data = {{16{w_half[15]}}, w_half};
            i_lubhw_con[LUB_LHU]: o_load_data = {16'd0, w_half};
            default:              o_load_data = '0;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one-entry register between execute and
// write-back, RAM read-word hold across stalls, load formatting.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_allowin_in,
   output logic        mem_allowin_out,
   input  logic        exe_valid_in,
   output logic        mem_valid_out,
   input  logic        wb_ClrStpJmp_in,
   input  logic [31:0] exe_alures_in,
   input  logic [4:0]  exe_sel_wbdata_in,
   input  logic [4:0]  exe_lubhw_con_in,
   input  logic [7:0]  exe_onehot_in,
   input  logic [31:0] exe_PC_in,
   input  logic [31:0] exe_NNPC_in,
   input  logic [4:0]  exe_wnum_in,
   input  logic [2:0]  exe_write_type_in,
   input  logic        exe_exception_in,
   input  logic        exe_bd_in,
   input  logic        exe_eret_in,
   input  logic [4:0]  exe_ExcCode_in,
   input  logic [7:0]  exe_cp0_addr_in,
   input  logic [1:0]  exe_mftc0_op_in,
   input  logic [31:0] exe_mtc0_data_in,
   input  logic [31:0] exe_error_VAddr_in,
   input  logic [31:0] dm_rdata_in,
   output logic [31:0] mem_load_data_out,
   output logic [31:0] mem_alures_out,
   output logic [4:0]  mem_sel_wbdata_out,
   output logic [4:0]  mem_lubhw_con_out,
   output logic [7:0]  mem_onehot_out,
   output logic [31:0] mem_PC_out,
   output logic [31:0] mem_NNPC_out,
   output logic [4:0]  mem_wnum_out,
   output logic [2:0]  mem_write_type_out,
   output logic        mem_exception_out,
   output logic        mem_bd_out,
   output logic        mem_eret_out,
   output logic [4:0]  mem_ExcCode_out,
   output logic [7:0]  mem_cp0_addr_out,
   output logic [1:0]  mem_mftc0_op_out,
   output logic [31:0] mem_mtc0_data_out,
   output logic [31:0] mem_error_VAddr_out,
   output logic        mem_exc_inflight_out
);

   logic        r_valid;
   logic        r_first;
   logic [31:0] r_hold;
   mem_pl_t     r_pl;
   mem_pl_t     w_in;
   logic        w_allowin;
   logic [31:0] w_rdata;

   assign w_in = '{
      alures:      exe_alures_in,
      sel_wbdata:  exe_sel_wbdata_in,
      lubhw_con:   exe_lubhw_con_in,
      onehot:      exe_onehot_in,
      pc:          exe_PC_in,
      nnpc:        exe_NNPC_in,
      wnum:        exe_wnum_in,
      write_type:  exe_write_type_in,
      exception:   exe_exception_in,
      bd:          exe_bd_in,
      eret:        exe_eret_in,
      exc_code:    exe_ExcCode_in,
      cp0_addr:    exe_cp0_addr_in,
      mftc0_op:    exe_mftc0_op_in,
      mtc0_data:   exe_mtc0_data_in,
      error_vaddr: exe_error_VAddr_in
   };

   assign w_allowin = !r_valid || wb_allowin_in || wb_ClrStpJmp_in;

   always_ff @(posedge clk) begin
      if (!rst_n || wb_ClrStpJmp_in) begin
         r_valid <= 1'b0;
         r_first <= 1'b0;
         r_pl    <= INI_PL;
      end else if (w_allowin) begin
         r_valid <= exe_valid_in;
         r_first <= exe_valid_in;
         r_pl    <= exe_valid_in ? w_in : INI_PL;
      end else begin
         r_first <= 1'b0;
      end
   end

   // RAM word is only live in the first cycle; keep it if WB stalls us
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_hold <= '0;
      else if (r_first && !wb_allowin_in)
         r_hold <= dm_rdata_in;
   end

   assign w_rdata = r_first ? dm_rdata_in : r_hold;

   load_align u_align (
      .i_rdata     (w_rdata),
      .i_rt        (r_pl.mtc0_data),
      .i_addr      (r_pl.alures[1:0]),
      .i_lubhw_con (r_pl.lubhw_con),
      .i_onehot    (r_pl.onehot),
      .o_load_data (mem_load_data_out)
   );

   assign mem_allowin_out      = w_allowin;
   assign mem_valid_out        = r_valid;
   assign mem_exc_inflight_out = r_valid && (r_pl.exception || r_pl.eret);
   assign mem_alures_out       = r_pl.alures;
   assign mem_sel_wbdata_out   = r_pl.sel_wbdata;
   assign mem_lubhw_con_out    = r_pl.lubhw_con;
   assign mem_onehot_out       = r_pl.onehot;
   assign mem_PC_out           = r_pl.pc;
   assign mem_NNPC_out         = r_pl.nnpc;
   assign mem_wnum_out         = r_pl.wnum;
   assign mem_write_type_out   = r_pl.write_type;
   assign mem_exception_out    = r_pl.exception;
   assign mem_bd_out           = r_pl.bd;
   assign mem_eret_out         = r_pl.eret;
   assign mem_ExcCode_out      = r_pl.exc_code;
   assign mem_cp0_addr_out     = r_pl.cp0_addr;
   assign mem_mftc0_op_out     = r_pl.mftc0_op;
   assign mem_mtc0_data_out    = r_pl.mtc0_data;
   assign mem_error_VAddr_out  = r_pl.error_vaddr;

endmodule
